// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte-stream requesters
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 16,
    localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_empty,
    input  logic                 tx_rd_en,
    input  logic                 tx_frame_done,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_POP  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [GW:0] N_REQ_W   = (GW+1)'(N_REQ);
    localparam logic [GW-1:0] LAST_ID = GW'(N_REQ - 1);
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [7:0]      burst_cnt;
    logic            last_flag;

    logic [2*N_REQ-1:0] rotated;
    logic [GW-1:0]      pick_off;
    logic [GW:0]        pick_sum;
    logic [GW-1:0]      pick_idx;
    logic               pick_found;
    logic [GW-1:0]      next_ptr;
    logic [7:0]         sel_data;

    // Rotate the request vector so that bit 0 is the round-robin pointer position.
    assign rotated = {req_valid, req_valid} >> ptr;

    // Lowest set bit of the rotated vector is the first requester at or after the pointer.
    always_comb begin
        pick_off   = '0;
        pick_found = |req_valid;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                pick_off = GW'(i);
            end
        end
        pick_sum = {1'b0, ptr} + {1'b0, pick_off};
        pick_idx = (pick_sum >= N_REQ_W) ? GW'(pick_sum - N_REQ_W) : pick_sum[GW-1:0];
    end

    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    assign sel_data = req_data[{grant_id, 3'b000} +: 8];

    // Only the grantee sees ready, and only while a byte may be staged.
    always_comb begin
        req_ready = '0;
        if (state == LOAD) begin
            req_ready[grant_id] = req_valid[grant_id];
        end
    end

    // Grant/staging state machine with registered transmitter-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            last_flag <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
            tx_data   <= '0;
            tx_empty  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (req_valid[grant_id]) begin
                        tx_data   <= sel_data;
                        tx_empty  <= 1'b0;
                        burst_cnt <= burst_cnt + 8'd1;
                        last_flag <= req_last[grant_id] || (burst_cnt == BURST_LAST);
                        state     <= WAIT_POP;
                    end else begin
                        // A stalled grantee gives up the line rather than blocking others.
                        ptr   <= next_ptr;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT_POP: begin
                    if (tx_rd_en) begin
                        tx_empty <= 1'b1;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_frame_done) begin
                        if (last_flag) begin
                            ptr   <= next_ptr;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with directed and randomized traffic
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BM = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [7:0]      tx_data;
    logic            tx_empty;
    logic            tx_rd_en;
    logic            tx_frame_done;
    logic [1:0]      grant_id;
    logic            busy;

    uart_tx_arbiter #(.N_REQ(N), .BURST_MAX(BM)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_empty      (tx_empty),
        .tx_rd_en      (tx_rd_en),
        .tx_frame_done (tx_frame_done),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          ready_cycles = 0;
    bit          auto_en = 1'b0;
    int          mptr = 0;
    logic [8:0]  rq [N][$];
    logic [9:0]  exp_q [$];
    logic [N-1:0] hs;
    int          tstate;
    int          tdly;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts ready cycles and scores every byte the transmitter pops.
    always @(negedge clk) begin
        logic [9:0] e;
        if (req_ready != '0) ready_cycles++;
        if (auto_en) begin
            if (req_ready != '0)
                chk("ready_onehot", 32'(($countones(req_ready) == 1) && ((req_ready & ~req_valid) == '0)), 1);
            if (tx_rd_en && !tx_empty) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {22'd0, grant_id, tx_data}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", 32'(tx_data), 32'(e[7:0]));
                    chk("pop_grant", 32'(grant_id), 32'(e[9:8]));
                end
            end
        end
    end

    // Reference model: whole messages, round robin, at most BM bytes per turn,
    // and a turn also ends when the requester runs dry.
    task automatic model_expect();
        logic [8:0] mq [N][$];
        logic [8:0] e;
        int g, cnt, idx;
        bit any;
        for (int i = 0; i < N; i++) mq[i] = rq[i];
        while (1) begin
            any = 1'b0;
            g = 0;
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (!any && mq[idx].size() > 0) begin
                    any = 1'b1;
                    g = idx;
                end
            end
            if (!any) break;
            cnt = 0;
            do begin
                e = mq[g].pop_front();
                exp_q.push_back({2'(g), e[7:0]});
                cnt++;
            end while (!e[8] && cnt < BM && mq[g].size() > 0);
            mptr = (g + 1) % N;
        end
    endtask

    task automatic push_msg(input int r, input int len, input bit with_last);
        for (int b = 0; b < len; b++)
            rq[r].push_back({with_last && (b == len - 1), 8'($urandom)});
    endtask

    task automatic gen_random();
        int nm, len;
        for (int i = 0; i < N; i++) begin
            nm = $urandom_range(0, 2);
            for (int m = 0; m < nm; m++) begin
                len = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 10) : $urandom_range(1, 3);
                push_msg(i, len, !((m == nm - 1) && ($urandom_range(0, 5) == 0)));
            end
        end
    endtask

    // Drives requesters from their queues and a randomly paced transmitter until drained.
    task automatic run_auto();
        int cyc;
        bit all_empty;
        model_expect();
        auto_en = 1'b1;
        tstate = 0;
        tdly = 0;
        cyc = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            cyc++;
            all_empty = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    all_empty = 1'b0;
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i] = rq[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
            tx_rd_en = 1'b0;
            tx_frame_done = 1'b0;
            if (tstate == 0) begin
                if (!tx_empty) begin
                    if (tdly == 0) begin
                        tx_rd_en = 1'b1;
                        tstate = 1;
                        tdly = $urandom_range(0, 4);
                    end else begin
                        tdly--;
                    end
                end
            end else begin
                if (tdly == 0) begin
                    tx_frame_done = 1'b1;
                    tx_rd_en = ($urandom_range(0, 3) == 0);
                    tstate = 0;
                    tdly = $urandom_range(0, 3);
                end else begin
                    tdly--;
                    tx_rd_en = ($urandom_range(0, 4) == 0);
                end
            end
            if (exp_q.size() == 0 && !busy && all_empty && tstate == 0 && !tx_frame_done) break;
        end
        chk("drain_in_time", 32'(cyc < 4000), 1);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        auto_en = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_rd_en = 1'b0;
        tx_frame_done = 1'b0;
        step();
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_rd_en = 1'b0;
        tx_frame_done = 1'b0;
        step();
        step();
        chk("rst_tx_empty", 32'(tx_empty), 1);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        base = ready_cycles;

        // Single one-byte message from requester 0.
        req_valid = 4'b0001;
        req_data[7:0] = 8'h55;
        req_last = 4'b0001;
        step();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(req_ready), 32'b0001);
        chk("t1_empty_in_load", 32'(tx_empty), 1);
        step();
        chk("t1_staged", 32'(tx_empty), 0);
        chk("t1_data", 32'(tx_data), 32'h55);
        chk("t1_grant", 32'(grant_id), 0);
        req_valid = '0;
        req_last = '0;
        step();
        step();
        tx_rd_en = 1'b1;
        step();
        tx_rd_en = 1'b0;
        chk("t1_popped", 32'(tx_empty), 1);
        repeat (19) step();
        tx_frame_done = 1'b1;
        step();
        tx_frame_done = 1'b0;
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_one_ready_pulse", 32'(ready_cycles - base), 1);

        // Pointer moved to 1: with 0 and 1 valid, 1 wins; then it stalls and releases.
        req_valid = 4'b0011;
        step();
        chk("ptr_grant", 32'(grant_id), 1);
        req_valid = '0;
        step();
        chk("stall_busy", 32'(busy), 0);
        chk("stall_nothing_staged", 32'(tx_empty), 1);

        // Requester 2 stalls after byte 1; requester 0 takes over.
        req_valid = 4'b0101;
        req_data = {8'h00, 8'hA1, 8'h00, 8'h9C};
        req_last = 4'b0001;
        step();
        chk("t5_grant", 32'(grant_id), 2);
        chk("t5_ready", 32'(req_ready), 32'b0100);
        step();
        chk("t5_data", 32'(tx_data), 32'hA1);
        req_valid = 4'b0001;
        #1;
        chk("t5_ready_in_pop", 32'(req_ready), 0);
        tx_rd_en = 1'b1;
        step();
        tx_rd_en = 1'b0;
        tx_frame_done = 1'b1;
        step();
        tx_frame_done = 1'b0;
        chk("t5_ready_stalled", 32'(req_ready), 0);
        chk("t5_busy_in_load", 32'(busy), 1);
        step();
        chk("t5_busy_fall", 32'(busy), 0);
        chk("t5_nothing_staged", 32'(tx_empty), 1);
        step();
        chk("t5_next_grant", 32'(grant_id), 0);
        chk("t5_next_ready", 32'(req_ready), 32'b0001);
        step();
        chk("t6_staged_data", 32'(tx_data), 32'h9C);
        chk("t6_staged", 32'(tx_empty), 0);
        req_valid = '0;
        req_last = '0;
        req_data = '0;

        // Reset in WAIT_POP, then spurious transmitter pulses while idle.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_rst_empty", 32'(tx_empty), 1);
        chk("t6_rst_data", 32'(tx_data), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_grant", 32'(grant_id), 0);
        tx_rd_en = 1'b1;
        step();
        tx_rd_en = 1'b0;
        tx_frame_done = 1'b1;
        step();
        tx_frame_done = 1'b0;
        step();
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_empty", 32'(tx_empty), 1);
        chk("t6_idle_data", 32'(tx_data), 0);

        // Four requesters, two one-byte messages each.
        for (int i = 0; i < N; i++) begin
            push_msg(i, 1, 1'b1);
            push_msg(i, 1, 1'b1);
        end
        run_auto();

        // Three-byte message on requester 2 competing with requester 1.
        rq[2].push_back({1'b0, 8'hA1});
        rq[2].push_back({1'b0, 8'hA2});
        rq[2].push_back({1'b1, 8'hA3});
        rq[1].push_back({1'b1, 8'h11});
        run_auto();

        // Long unterminated stream on requester 0 forced to rotate with requester 3.
        for (int b = 0; b < 10; b++) rq[0].push_back({1'b0, 8'(8'h40 + b)});
        push_msg(3, 2, 1'b1);
        run_auto();

        for (int s = 0; s < 8; s++) begin
            gen_random();
            run_auto();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
